// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between fetch and MEM.
// One access in flight; fixed-latency read path with one-cycle ready pulses.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ready,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          pipe_stall
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] LAT_C = 3'(LAT);

    logic [1:0] state;
    logic [2:0] cnt;
    logic       owner;
    logic       last_grant;
    logic       we_q;
    logic       any_req;
    logic       grant_mem;

    // On conflict the port that did not win last time gets the RAM.
    always_comb begin
        any_req   = if_req | mem_req;
        grant_mem = mem_req & (~if_req | ~last_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            we_q       <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state      <= S_ISSUE;
                        owner      <= grant_mem;
                        last_grant <= grant_mem;
                        we_q       <= grant_mem & mem_we;
                        ram_addr   <= grant_mem ? mem_addr : if_addr;
                        ram_wdata  <= (grant_mem & mem_we) ? mem_wdata : '0;
                        cnt        <= LAT_C;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= S_DONE;
                        if (!owner) begin
                            if_rdata <= ram_rdata;
                        end else if (!we_q) begin
                            mem_rdata <= ram_rdata;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Requests seen in DONE are ignored so the requester can move on.
    always_comb begin
        ram_en     = (state == S_ISSUE);
        ram_we     = ram_en & we_q;
        if_ready   = (state == S_DONE) & ~owner;
        mem_ready  = (state == S_DONE) & owner;
        pipe_stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data RAM between the instruction-fetch stage and the MEM stage of the 5-stage pipeline. It sequences each access through a fixed-latency RAM protocol and returns read data with a one-cycle ready pulse. It produces the pipeline stall that drives the hazard path's `stall_en` input. Only one RAM access is ever in flight. Fetch/data conflicts are resolved round-robin.

## Interface
Parameters:
- `AW`, 32, address width (byte address, passed through unchanged)
- `DW`, 32, data width
- `LAT`, 1, RAM read latency in cycles, legal range 1..7

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held until `if_ready`
- `if_addr`  in  AW  fetch address; stable while `if_req`
- `if_rdata`  out  DW  fetched instruction; valid when `if_ready`, otherwise holds its last value
- `if_ready`  out  1  one-cycle completion pulse for fetch
- `mem_req`  in  1  data request; held until `mem_ready`
- `mem_we`  in  1  1 = store, 0 = load; stable while `mem_req`
- `mem_addr`  in  AW  data address
- `mem_wdata`  in  DW  store data
- `mem_rdata`  out  DW  load data; valid when `mem_ready` for a load
- `mem_ready`  out  1  one-cycle completion pulse for data
- `ram_en`  out  1  RAM access strobe, one cycle per access
- `ram_we`  out  1  RAM write enable; high only together with `ram_en`
- `ram_addr`  out  AW  RAM address (registered)
- `ram_wdata`  out  DW  RAM write data (registered)
- `ram_rdata`  in  DW  RAM read data; valid LAT cycles after the `ram_en` cycle
- `pipe_stall`  out  1  `(if_req & ~if_ready) | (mem_req & ~mem_ready)`, combinational

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Registers: `owner` (0 = IF, 1 = MEM), `last_grant`, `cnt` (3 bits).
- IDLE with no request: stay in IDLE.
- IDLE with exactly one request: grant it and go to ISSUE.
- IDLE with both requests: grant the port that is not `last_grant`. `last_grant` resets to IF, so the first conflict goes to MEM.
- On a grant:
  - `owner` and `last_grant` take the winner.
  - `ram_addr`, `ram_we` and `ram_wdata` are registered from the winner. IF is always a read, and `ram_wdata` is 0 for a read.
  - `cnt` loads LAT.
- ISSUE: `ram_en` = 1 and `ram_we` = the owner's `we`. The next state is WAIT.
- WAIT: `ram_en` = `ram_we` = 0. `cnt` decrements each cycle.
  - When `cnt` == 1, `ram_rdata` is sampled into the owner's rdata register, and the next state is DONE.
  - For a store the sample is suppressed, so `mem_rdata` keeps its value.
- DONE: the owner's ready = 1 for exactly this cycle. Requests are ignored in DONE, which lets the requester drop or change `req` on the following edge. The next state is IDLE.
- A request that is not granted stays pending with no side effects.
- `ram_addr`/`ram_wdata` hold their values outside ISSUE.
- Reset, asynchronous and possible mid-access:
  - State = IDLE, `cnt` = 0, `owner` = 0, `last_grant` = IF.
  - `ram_en` = `ram_we` = 0; `ram_addr`, `ram_wdata`, `if_rdata` and `mem_rdata` = 0.
  - `if_ready` = `mem_ready` = 0.
  - An in-flight access is abandoned and no ready is produced for it. A store already strobed may have completed in the RAM.

## Timing
- The request is seen in cycle 0 (IDLE). `ram_en` is high in cycle 1, `ram_rdata` is valid in cycle 1+LAT, and ready is high in cycle 2+LAT.
- The arbiter is back in IDLE in cycle 3+LAT and can grant in that cycle.
- Occupancy per access: LAT+3 cycles. With LAT = 1, ready arrives in cycle 3 and the next grant is in cycle 4.
- Stores use the same timing as loads.
- `pipe_stall` is combinational from `req`/ready, so it is low in the ready cycle and the pipeline advances on that edge.

## Test plan
- Single fetch, LAT = 1: `if_req` with `if_addr` = 0x40 in cycle 0, RAM returns 0x1234_5678 in cycle 2.
  - Required: `ram_en` and `ram_addr` = 0x40 in cycle 1.
  - Required: `if_ready` = 1 with `if_rdata` = 0x1234_5678 in cycle 3, `pipe_stall` high in cycles 0–2.
- Store, LAT = 3: `mem_we` = 1, `mem_addr` = 0x100, `mem_wdata` = 0xDEAD_BEEF.
  - Required: `ram_en` = `ram_we` = 1 with those values in cycle 1 only.
  - Required: `mem_ready` in cycle 5 with `mem_rdata` unchanged.
- Conflict: `if_req` and `mem_req` both held from reset, LAT = 1.
  - Required: MEM is served first with `mem_ready` in cycle 3.
  - Required: IF is granted in cycle 4 with `if_ready` in cycle 7.
  - Required: with both held, grants alternate MEM/IF, and no port ever wins twice in a row while the other is pending.
- Request ignored in DONE: `if_req` is held through the ready cycle and deasserted the cycle after.
  - Required: exactly one `ram_en` and one `if_ready`.
- Reset mid-access: assert `rst_n` low in the WAIT state with LAT = 3.
  - Required: all outputs are 0 immediately, asynchronously.
  - Required: after release, no stale ready appears, and a new request completes normally.
- Back-to-back loads to 0x0, 0x4, 0x8 with LAT = 2.
  - Required: `ram_en` in cycles 1, 6 and 11.
  - Required: each `mem_rdata` matches the RAM model value.
